// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Optional feature macro: SIGNED_MODE_EN (adds the Sgn operand-select path).
package mult_pkg;

  // Default operand width; legal range is 2..32.
  localparam int unsigned DEF_WIDTH = 8;

  // Control FSM encoding; 2'b11 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/operand/status/product bundle for seq_multiplier.
// Optional feature macro: SIGNED_MODE_EN (adds sgn).
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = mult_pkg::DEF_WIDTH
);
  logic                 st;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef SIGNED_MODE_EN
  logic                 sgn;
`endif
  logic                 idle;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

`ifdef SIGNED_MODE_EN
  modport master (output st, a, b, sgn, input idle, busy, done, p);
  modport slave  (input st, a, b, sgn, output idle, busy, done, p);
`else
  modport master (output st, a, b, input idle, busy, done, p);
  modport slave  (input st, a, b, output idle, busy, done, p);
`endif
endinterface

// File: rtl/mult_control.sv
// Control FSM and bit counter for seq_multiplier. Status outputs are registered
// alongside the state so they are glitch-free and mutually exclusive.
module mult_control
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic st_i,
  output logic idle_o,
  output logic busy_o,
  output logic done_o,
  output logic load_o,
  output logic step_o,
  output logic last_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             idle_q;
  logic             busy_q;
  logic             done_q;

  // State, bit counter and registered status flags advance together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (st_i) begin
            state_q <= S_CALC;
            cnt_q   <= '0;
            idle_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // St is ignored here; always return to idle for one cycle.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idle_q  <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idle_o = idle_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign load_o = (state_q == S_IDLE) && st_i;
  assign step_o = (state_q == S_CALC);
  assign last_o = (state_q == S_CALC) && (cnt_q == CntLast);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one add-and-shift per cycle, WIDTH cycles
// per product. Datapath lives here; sequencing is in mult_control.
// Optional feature macro: SIGNED_MODE_EN (two's-complement operands via sgn).
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  seq_multiplier_if.slave bus
);

  logic load;
  logic step;
  logic last;

  logic [WIDTH-1:0] mcand_q;
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_d;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  mult_control #(
    .WIDTH (WIDTH)
  ) u_control (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .st_i   (bus.st),
    .idle_o (bus.idle),
    .busy_o (bus.busy),
    .done_o (bus.done),
    .load_o (load),
    .step_o (step),
    .last_o (last)
  );

`ifdef SIGNED_MODE_EN
  logic           sgn_q;
  logic [WIDTH:0] mcand_ext;

  // Signed iteration: sign-extended addend, subtract on the final (sign) bit,
  // arithmetic right shift.
  always_comb begin
    mcand_ext = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    addend    = '0;
    if (acc_q[0]) begin
      addend = (sgn_q && last) ? -mcand_ext : mcand_ext;
    end
    sum   = acc_q[2*WIDTH:WIDTH] + addend;
    acc_d = {(sgn_q ? sum[WIDTH] : 1'b0), sum, acc_q[WIDTH-1:1]};
  end

  // Sign select is captured together with the operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sgn_q <= 1'b0;
    end else if (load) begin
      sgn_q <= bus.sgn;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Unsigned iteration: conditional add with carry kept, logical right shift.
  always_comb begin
    addend = acc_q[0] ? {1'b0, mcand_q} : '0;
    sum    = acc_q[2*WIDTH:WIDTH] + addend;
    acc_d  = {1'b0, sum, acc_q[WIDTH-1:1]};
  end
`endif

  // Operand capture on accepted start, one shift-add per CALC cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (load) begin
      mcand_q <= bus.a;
      acc_q   <= {{(WIDTH+1){1'b0}}, bus.b};
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  assign bus.p = acc_q[2*WIDTH-1:0];

endmodule
